// File: rtl/line_cmd_queue_pkg.sv
// line_cmd_pkg: shared types for the line-command queue.
//   line_cmd_t  - one packed line-draw command, {colour, y1, x1, y0, x0} (37 bits)
//   lq_state_e  - sequencer states (idle / line in flight / waiting for done to drop)
package line_cmd_pkg;

    localparam int X_W   = 9;
    localparam int Y_W   = 8;
    localparam int C_W   = 3;
    localparam int CMD_W = C_W + 2 * Y_W + 2 * X_W;

    typedef struct packed {
        logic [C_W-1:0] colour;
        logic [Y_W-1:0] y1;
        logic [X_W-1:0] x1;
        logic [Y_W-1:0] y0;
        logic [X_W-1:0] x0;
    } line_cmd_t;

    typedef enum logic [1:0] {
        LQ_IDLE    = 2'd0,
        LQ_RUN     = 2'd1,
        LQ_RELEASE = 2'd2
    } lq_state_e;

endpackage

// File: rtl/line_cmd_queue_if.sv
// line_cmd_queue_if: command-producer side of the line-command queue.
//   cmd_valid  producer -> queue   command present
//   cmd_ready  queue -> producer   queue not full
//   cmd_data   producer -> queue   packed line command
//   flush      producer -> queue   discard every queued (not in-flight) command
interface line_cmd_queue_if;
    import line_cmd_pkg::*;

    logic      cmd_valid;
    logic      cmd_ready;
    line_cmd_t cmd_data;
    logic      flush;

    modport master (output cmd_valid, output cmd_data, output flush, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_data, input flush, output cmd_ready);

endinterface

// File: rtl/line_cmd_queue_fifo.sv
// line_cmd_fifo: synchronous DEPTH-entry FIFO of line commands.
//   clk, reset_n   clock, async active-low reset
//   push_i/wdata_i write request (ignored when full or flushing)
//   pop_i          read request (ignored when empty or flushing)
//   flush_i        empties the FIFO on the next edge
//   rdata_o        head entry (valid while !empty_o)
//   count_o        occupancy, full_o/empty_o derived from it
module line_cmd_fifo
    import line_cmd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  line_cmd_t        wdata_i,
    output line_cmd_t        rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    line_cmd_t        mem_q [DEPTH];
    logic             do_push, do_pop;

    // Pointers wrap naturally (DEPTH is a power of two); the separate count
    // distinguishes full from empty when the pointers are equal.
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i  && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/line_cmd_queue.sv
// line_cmd_queue: buffers line-draw commands and issues them one at a time
// to the line drawer through its start/done handshake.
//   clk, reset_n        clock, async active-low reset
//   cmd (slave)         producer handshake: cmd_valid/cmd_ready/cmd_data/flush
//   start  out          held high while a line is in flight
//   done   in           drawer reports line complete
//   x0,y0,x1,y1,colour  endpoints/colour of the current (or last) line
//   busy   out          line in flight or queue non-empty
//   count  out          queued entries, excluding the in-flight line
module line_cmd_queue
    import line_cmd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    line_cmd_queue_if.slave  cmd,
    output logic             start,
    input  logic             done,
    output logic [X_W-1:0]   x0,
    output logic [X_W-1:0]   x1,
    output logic [Y_W-1:0]   y0,
    output logic [Y_W-1:0]   y1,
    output logic [C_W-1:0]   colour,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    lq_state_e        state_q;
    logic             start_q;
    line_cmd_t        line_q;
    line_cmd_t        head;
    logic             fifo_full, fifo_empty;
    logic             pop;

    // Flush wins over pop: a flush in IDLE leaves nothing to issue.
    assign pop = (state_q == LQ_IDLE) && !fifo_empty && !cmd.flush;

    line_cmd_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (cmd.cmd_valid),
        .pop_i   (pop),
        .flush_i (cmd.flush),
        .wdata_i (cmd.cmd_data),
        .rdata_o (head),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Readiness comes from the registered occupancy only, so a full queue
    // refuses a push even on the edge that pops.
    assign cmd.cmd_ready = !fifo_full;

    // RELEASE waits for done to fall so a level-held done from the previous
    // line can never be mistaken for completion of the next one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= LQ_IDLE;
            start_q <= 1'b0;
            line_q  <= '0;
        end else begin
            case (state_q)
                LQ_IDLE: begin
                    if (pop) begin
                        line_q  <= head;
                        start_q <= 1'b1;
                        state_q <= LQ_RUN;
                    end
                end
                LQ_RUN: begin
                    if (done) begin
                        start_q <= 1'b0;
                        state_q <= LQ_RELEASE;
                    end
                end
                LQ_RELEASE: begin
                    if (!done) state_q <= LQ_IDLE;
                end
                default: begin
                    start_q <= 1'b0;
                    state_q <= LQ_IDLE;
                end
            endcase
        end
    end

    assign start  = start_q;
    assign x0     = line_q.x0;
    assign y0     = line_q.y0;
    assign x1     = line_q.x1;
    assign y1     = line_q.y1;
    assign colour = line_q.colour;
    assign busy   = (state_q != LQ_IDLE) || !fifo_empty;

endmodule
